// File: rtl/gray_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gray_pkg
// Description : Shared types and constants for the Gray-to-binary decoder:
//               controller state encoding and default word width.
// Revision    : 1.0 - initial release
// ============================================================================
package gray_pkg;

   // Default Gray/binary word width (legal range 2..16)
   localparam int c_DEFAULT_WIDTH = 4;

   // Controller states; explicit 2-bit encoding
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : gray_pkg
`default_nettype wire

// File: rtl/gray_adj_check.sv
`default_nettype none
// ============================================================================
// Module      : gray_adj_check
// Description : Combinational adjacency check. Flags when two words are NOT
//               exactly Hamming distance 1 apart (identical words also flag).
// Revision    : 1.0 - initial release
// ============================================================================
module gray_adj_check
   import gray_pkg::*;
#(
   parameter int WIDTH = c_DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] word_a,
   input  logic [WIDTH-1:0] word_b,
   output logic             not_adjacent
);

   logic [WIDTH-1:0] w_diff;
   logic [WIDTH-1:0] w_diff_dec;
   logic             w_single;

   // Exactly one differing bit <=> diff is non-zero and a power of two,
   // which avoids building a full popcount adder tree.
   always_comb begin
      w_diff       = word_a ^ word_b;
      w_diff_dec   = w_diff - WIDTH'(1);
      w_single     = (w_diff != '0) && ((w_diff & w_diff_dec) == '0);
      not_adjacent = ~w_single;
   end

endmodule : gray_adj_check
`default_nettype wire

// File: rtl/gray2binary_decoder.sv
`default_nettype none
// ============================================================================
// Module      : gray2binary_decoder
// Description : Bit-serial Gray-to-binary decoder with valid/ready handshakes.
//               Resolves one bit per cycle MSB first, then holds the result
//               with an adjacency-error flag relative to the previous word.
// Revision    : 1.0 - initial release
// ============================================================================
module gray2binary_decoder
   import gray_pkg::*;
#(
   parameter int WIDTH = c_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] gray,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] binary,
   output logic             adj_err
);

   localparam int                 c_IDX_W   = $clog2(WIDTH);
   localparam logic [c_IDX_W-1:0] c_IDX_TOP = c_IDX_W'(WIDTH - 1);

   state_t             r_state;
   state_t             w_state_next;

   logic [WIDTH-1:0]   r_gray;
   logic [WIDTH-1:0]   r_prev_gray;
   logic [WIDTH-1:0]   r_binary;
   logic [WIDTH-1:0]   w_binary_next;
   logic [WIDTH-1:0]   w_upper;
   logic [c_IDX_W-1:0] r_idx;
   logic               r_hist_valid;
   logic               r_adj_err;
   logic               r_out_valid;
   logic               w_adj_flag;
   logic               w_accept;
   logic               w_handshake;
   logic               w_last_bit;

   // Distance check runs on the live input so the flag is ready at acceptance
   gray_adj_check #(
      .WIDTH (WIDTH)
   ) u_adj_check (
      .word_a       (gray),
      .word_b       (r_prev_gray),
      .not_adjacent (w_adj_flag)
   );

   // Handshake qualifiers and per-bit decode step
   always_comb begin
      w_accept      = (r_state == IDLE) && in_valid;
      w_handshake   = r_out_valid && out_ready;
      w_last_bit    = (r_idx == '0);
      // Bit above the current index; the MSB sees a zero above it so that
      // binary[MSB] = gray[MSB] falls out of the same XOR.
      w_upper       = {1'b0, r_binary[WIDTH-1:1]};
      w_binary_next = r_binary;
      w_binary_next[r_idx] = w_upper[r_idx] ^ r_gray[r_idx];
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic and state-decoded outputs
   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_state_next = CONV;
            end
         end
         CONV: begin
            if (w_last_bit) begin
               w_state_next = DONE;
            end
         end
         DONE: begin
            if (w_handshake) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // Capture, serial decode and adjacency history
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gray       <= '0;
         r_prev_gray  <= '0;
         r_binary     <= '0;
         r_idx        <= '0;
         r_hist_valid <= 1'b0;
         r_adj_err    <= 1'b0;
      end else if (w_accept) begin
         r_gray       <= gray;
         r_prev_gray  <= gray;
         r_binary     <= '0;
         r_idx        <= c_IDX_TOP;
         r_hist_valid <= 1'b1;
         r_adj_err    <= r_hist_valid & w_adj_flag;
      end else if (r_state == CONV) begin
         r_binary <= w_binary_next;
         if (!w_last_bit) begin
            r_idx <= r_idx - c_IDX_W'(1);
         end
      end
   end

   // Result presentation is registered: out_valid rises one edge after the
   // controller reaches DONE and drops on the handshake edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= (r_state == DONE) && !w_handshake;
      end
   end

   assign out_valid = r_out_valid;
   assign binary    = r_binary;
   assign adj_err   = r_adj_err;

endmodule : gray2binary_decoder
`default_nettype wire

// File: doc/gray2binary_decoder.md
GRAY2BINARY_DECODER -- requirements
Module: gray2binary_decoder

Interface
REQ-001 Parameter: WIDTH, default 4, Gray/binary word width; legal range 2..16.
REQ-002 Port: clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 Port: rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 Port: in_valid, input, 1, the value on gray is offered.
REQ-005 Port: in_ready, output, 1, block can accept a word.
REQ-006 Port: gray, input, WIDTH, Gray-coded word; sampled only on handshake.
REQ-007 Port: out_valid, output, 1, binary and adj_err hold a result.
REQ-008 Port: out_ready, input, 1, consumer accepts the result.
REQ-009 Port: binary, output, WIDTH, decoded binary word.
REQ-010 Port: adj_err, output, 1, accepted word is not Hamming-distance-1 from the previous accepted word.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, CONV and DONE.
REQ-012 IDLE SHALL drive in_ready=1 and out_valid=0; in_ready SHALL be 0 in CONV and in DONE.
REQ-013 IDLE: on in_valid=1 at a clock edge, the block SHALL capture gray, clear the binary result register, load bit index WIDTH-1 and move to CONV.
REQ-014 CONV: each cycle SHALL resolve one bit, MSB first: binary[WIDTH-1]=gray[WIDTH-1]; binary[i]=binary[i+1] XOR gray[i]; the index then decrements.
REQ-015 CONV: after bit 0 is resolved, the block SHALL move to DONE; CONV lasts exactly WIDTH cycles.
REQ-016 Latency: out_valid SHALL rise exactly WIDTH+1 rising edges after the acceptance edge.
REQ-017 DONE: out_valid=1; binary and adj_err SHALL stay stable until out_valid and out_ready are both 1 at an edge; the block then returns to IDLE.
REQ-018 Throughput: the block SHALL take at most one word per WIDTH+2 cycles; in_valid SHALL be ignored outside IDLE.
REQ-019 binary SHALL show partial results during CONV; consumers SHALL use it only while out_valid=1.
REQ-020 adj_err SHALL be 1 when a previously accepted word exists and popcount(gray XOR prev_gray) != 1, so an identical repeat also flags.
REQ-021 adj_err SHALL be 0 for the first word accepted after reset.
REQ-022 prev_gray SHALL update to the accepted word at each acceptance edge.
REQ-023 adj_err SHALL be computed at acceptance, registered, and held through DONE.

Reset
REQ-024 When rst_n=0, the block SHALL immediately enter IDLE, with in_ready=1, out_valid=0, binary=0, adj_err=0, and the history-valid flag cleared.
REQ-025 Reset asserted during CONV or DONE SHALL discard the word in flight; no out_valid SHALL follow it.
REQ-026 After rst_n is deasserted, the first acceptance SHALL occur no earlier than the first rising edge.

Structure
REQ-027 Package gray_pkg SHALL hold the state enum typedef (IDLE, CONV, DONE) and the default WIDTH constant.
REQ-028 Sub-module gray_adj_check SHALL be combinational, take two WIDTH-bit words, and output the distance-not-one flag.
REQ-029 The bit index SHALL be $clog2(WIDTH) bits wide, and the implementation SHALL contain no other counters.

Verification (WIDTH=4)
REQ-030 Exhaustive decode: send each of the 16 Gray codes with out_ready=1 -> binary matches the Gray-to-binary map, e.g. 1000->1111, 1100->1000, 0011->0010.
REQ-031 Latency/handshake: accept 0001 at edge N with out_ready=1 -> out_valid=1 after edge N+5 with binary=0001; in_ready=0 during edges N+1..N+5.
REQ-032 Backpressure: hold out_ready=0 for 10 cycles in DONE -> binary and out_valid stay stable and in_valid pulses are ignored; raising out_ready -> IDLE on the next edge.
REQ-033 Adjacency: send 0000, 0001, 0011, 0110, 0110 -> adj_err = 0, 0, 0, 1, 1.
REQ-034 Mid-operation reset: pulse rst_n low two cycles after accepting 1010 -> out_valid never rises for that word; the next word 1011 reports adj_err=0 and binary=1101.
